riscv_cpu_top: RTL and testbench



---
 rtl/riscv_cpu_top.sv | 257 +++++++++++++++++++++++++
 tb/tb_riscv_cpu_top.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_cpu_top.sv
// Single-cycle RV32I-subset CPU: PC, instruction ROM, register file, ALU,
// branch unit and word-addressed data memory. One instruction per clock.
// Reset is synchronous, active-low (rst == 0 at a rising edge).
// Optional macro CPU_TRACE_EN adds a simulation-only commit trace.

// Instruction ROM, preloaded by the environment and never written by the core.
module riscv_imem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    output logic [31:0]              instr_c_o
);
    logic [31:0] IM [0:DEPTH-1];

    assign instr_c_o = IM[idx_i];
endmodule

// 32x32 register file, two combinational read ports, x0 hard-wired to zero.
module riscv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_c_o,
    output logic [31:0] rs2_data_c_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] register [0:31];

    assign rs1_data_c_o = (rs1_addr_i == 5'd0) ? 32'd0 : register[rs1_addr_i];
    assign rs2_data_c_o = (rs2_addr_i == 5'd0) ? 32'd0 : register[rs2_addr_i];

    // Clear on reset, otherwise commit one write per edge (x0 writes dropped).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) register[i] <= 32'd0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            register[waddr_i] <= wdata_i;
        end
    end
endmodule

// Word-addressed data memory: asynchronous read, write at the edge.
module riscv_dmem #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic                     we_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_c_o
);
    logic [31:0] DATA [0:DEPTH-1];

    assign rdata_c_o = DATA[idx_i];

    // Clear on reset, otherwise store the word selected by the address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) DATA[i] <= 32'd0;
        end else if (we_i) begin
            DATA[idx_i] <= wdata_i;
        end
    end
endmodule

module riscv_cpu_top #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc, pc_d, pc_plus4, instr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_y;
    logic        alu_sub, alu_ok, br_take;
    logic        rd_we, st_we;
    logic [31:0] rd_wdata, mem_addr, ld_data;
    logic        unused_addr_bits;

    riscv_imem #(.DEPTH(IMEM_DEPTH)) MyInstr_Mem (
        .idx_i     (pc[IMEM_AW+1:2]),
        .instr_c_o (instr)
    );

    riscv_regfile MyregisterFile (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr_i   (rs1),
        .rs2_addr_i   (rs2),
        .rs1_data_c_o (rs1_val),
        .rs2_data_c_o (rs2_val),
        .we_i         (rd_we),
        .waddr_i      (rd),
        .wdata_i      (rd_wdata)
    );

    riscv_dmem #(.DEPTH(DMEM_DEPTH)) MyMDR (
        .clk       (clk),
        .rst       (rst),
        .idx_i     (mem_addr[DMEM_AW+1:2]),
        .we_i      (st_we),
        .wdata_i   (rs2_val),
        .rdata_c_o (ld_data)
    );

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'd0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

    // Byte-offset and out-of-range address bits are intentionally ignored.
    assign unused_addr_bits = ^{mem_addr[31:DMEM_AW+2], mem_addr[1:0]};

    // ALU shared by OP and OP-IMM, with legality of the funct7 encoding.
    always_comb begin
        alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
        alu_sub = (opcode == OPC_OP) && funct7[5];
        alu_ok  = 1'b1;
        alu_y   = 32'd0;
        if (opcode == OPC_OP) begin
            alu_ok = (funct7 == 7'h00) ||
                     ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (funct3 == 3'b001) begin
            alu_ok = (funct7 == 7'h00);
        end else if (funct3 == 3'b101) begin
            alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
        case (funct3)
            3'b000:  alu_y = alu_sub ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'b001:  alu_y = rs1_val << alu_b[4:0];
            3'b010:  alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_y = {31'd0, rs1_val < alu_b};
            3'b100:  alu_y = rs1_val ^ alu_b;
            3'b101:  alu_y = funct7[5] ? 32'($signed(rs1_val) >>> alu_b[4:0])
                                       : (rs1_val >> alu_b[4:0]);
            3'b110:  alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    // Branch condition; reserved funct3 codes never take.
    always_comb begin
        br_take = 1'b0;
        case (funct3)
            3'b000:  br_take = (rs1_val == rs2_val);
            3'b001:  br_take = (rs1_val != rs2_val);
            3'b100:  br_take = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_take = (rs1_val <  rs2_val);
            3'b111:  br_take = (rs1_val >= rs2_val);
            default: br_take = 1'b0;
        endcase
    end

    // Decode: register write, store enable and next PC; unknowns act as NOP.
    always_comb begin
        pc_d     = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = 32'd0;
        st_we    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_plus4;
                    pc_d     = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (br_take) pc_d = pc + imm_b;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    rd_we    = 1'b1;
                    rd_wdata = ld_data;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) st_we = 1'b1;
            end
            OPC_OPIMM, OPC_OP: begin
                if (alu_ok) begin
                    rd_we    = 1'b1;
                    rd_wdata = alu_y;
                end
            end
            default: ;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= pc_d;
    end

`ifdef CPU_TRACE_EN
    // Commit trace, one line per retired instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (rd_we && (rd != 5'd0))
                $display("TRACE pc=%08h instr=%08h rd=x%0d val=%08h", pc, instr, rd, rd_wdata);
            else
                $display("TRACE pc=%08h instr=%08h rd=-", pc, instr);
            if (st_we)
                $display("TRACE   store addr=%08h data=%08h", mem_addr, rs2_val);
        end
    end
`else
    // Trace disabled: no additional logic.
`endif
endmodule

// File: tb/tb_riscv_cpu_top.sv
// Scoreboard bench for riscv_cpu_top: an instruction-level reference model
// predicts architectural state after every edge; a monitor compares it.
module tb_riscv_cpu_top;
    localparam int unsigned IMEM_DEPTH = 256;
    localparam int unsigned DMEM_DEPTH = 64;

    typedef struct {
        logic [31:0] pc;
        int          ridx;
        logic [31:0] rval;
        int          didx;
        logic [31:0] dval;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] prog  [IMEM_DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_reg [32];
    logic [31:0] m_dm  [DMEM_DEPTH];
    exp_t        sb_q  [$];

    always #5 clk = ~clk;

    riscv_cpu_top #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] alu_ref(logic [2:0] op, bit alt, logic [31:0] x, logic [31:0] y);
        int unsigned sh;
        sh = y % 32;
        case (op)
            3'd0: return alt ? (x - y) : (x + y);
            3'd1: return x << sh;
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: begin
                if (alt) return 32'($signed(x) >>> sh);
                return x >> sh;
            end
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        for (int i = 0; i < int'(DMEM_DEPTH); i++) m_dm[i] = 32'h0;
    endtask

    // Execute one instruction architecturally; report written rd and stored word.
    task automatic model_exec(output int wr_rd, output int st_idx);
        logic [31:0] ins, a, b, ii, is, ib, ij, iu, res, npc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          rd, rs1, rs2;
        bit          wr, ok, take;
        ins  = prog[(m_pc >> 2) % IMEM_DEPTH];
        rd   = int'(ins[11:7]);
        rs1  = int'(ins[19:15]);
        rs2  = int'(ins[24:20]);
        f3   = ins[14:12];
        f7   = ins[31:25];
        a    = m_reg[rs1];
        b    = m_reg[rs2];
        ii   = 32'($signed(ins) >>> 20);
        is   = (ii & ~32'h1F) | 32'(ins[11:7]);
        ib   = (ins[31] ? 32'hFFFFF000 : 32'h0) | (32'(ins[7]) << 11) |
               (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        ij   = (ins[31] ? 32'hFFF00000 : 32'h0) | (32'(ins[19:12]) << 12) |
               (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        iu   = ins & 32'hFFFFF000;
        npc  = m_pc + 32'd4;
        wr   = 1'b0;
        res  = 32'h0;
        st_idx = -1;
        case (ins[6:0])
            7'b0110111: begin wr = 1'b1; res = iu; end
            7'b0010111: begin wr = 1'b1; res = m_pc + iu; end
            7'b1101111: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ij; end
            7'b1100111: if (f3 == 3'd0) begin
                wr = 1'b1; res = m_pc + 32'd4; npc = (a + ii) & 32'hFFFFFFFE;
            end
            7'b1100011: begin
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) <  $signed(b));
                    3'd5: take = ($signed(a) >= $signed(b));
                    3'd6: take = (a <  b);
                    3'd7: take = (a >= b);
                    default: take = 1'b0;
                endcase
                if (take) npc = m_pc + ib;
            end
            7'b0000011: if (f3 == 3'd2) begin
                wr = 1'b1; res = m_dm[((a + ii) >> 2) % DMEM_DEPTH];
            end
            7'b0100011: if (f3 == 3'd2) begin
                st_idx = int'(((a + is) >> 2) % DMEM_DEPTH);
                m_dm[st_idx] = b;
            end
            7'b0010011: begin
                ok = !((f3 == 3'd1) && (f7 != 7'h00)) &&
                     !((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
                if (ok) begin wr = 1'b1; res = alu_ref(f3, (f3 == 3'd5) && f7[5], a, ii); end
            end
            7'b0110011: begin
                ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                if (ok) begin wr = 1'b1; res = alu_ref(f3, f7[5], a, b); end
            end
            default: ;
        endcase
        if (wr && rd != 0) m_reg[rd] = res;
        wr_rd = (wr && rd != 0) ? rd : -1;
        m_pc  = npc;
    endtask

    // Advance the model by one edge and push the predicted state.
    task automatic model_edge(input bit do_reset);
        exp_t e;
        int   wr_rd, st_idx;
        if (do_reset) begin
            model_reset();
            wr_rd  = -1;
            st_idx = -1;
        end else begin
            model_exec(wr_rd, st_idx);
        end
        e.pc   = m_pc;
        e.ridx = (wr_rd >= 0) ? wr_rd : int'($urandom_range(0, 31));
        e.rval = m_reg[e.ridx];
        e.didx = (st_idx >= 0) ? st_idx : int'($urandom_range(0, DMEM_DEPTH - 1));
        e.dval = m_dm[e.didx];
        sb_q.push_back(e);
    endtask

    task automatic do_edge(input logic r);
        @(negedge clk);
        rst = r;
        model_edge(r == 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic full_check();
        chk("pc_full", dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            chk($sformatf("reg_full x%0d", i), dut.MyregisterFile.register[i], m_reg[i]);
        for (int i = 0; i < int'(DMEM_DEPTH); i++)
            chk($sformatf("dmem_full DATA[%0d]", i), dut.MyMDR.DATA[i], m_dm[i]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        r   = $urandom;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = r[14:12];
        case ($urandom_range(0, 11))
            0:  return {r[31:12], rd, 7'b0110111};
            1:  return {r[31:12], rd, 7'b0010111};
            2:  return {r[31:12], rd, 7'b1101111};
            3:  return {r[31:20], rs1, 3'b000, rd, 7'b1100111};
            4, 5: return {r[31:25], rs2, rs1, f3, r[11:7], 7'b1100011};
            6:  return {r[31:20], rs1, 3'b010, rd, 7'b0000011};
            7:  return {r[31:25], rs2, rs1, 3'b010, r[11:7], 7'b0100011};
            8, 9: begin
                f7 = (f3 == 3'd1) ? 7'h00 : (f3 == 3'd5) ? {1'b0, r[30], 5'd0} : r[31:25];
                return {f7, r[24:20], rs1, f3, rd, 7'b0010011};
            end
            10: begin
                f7 = r[0] ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            default: return r;
        endcase
    endfunction

    task automatic load_random_program();
        for (int i = 0; i < int'(IMEM_DEPTH); i++) prog[i] = rand_instr();
        @(negedge clk);
        for (int i = 0; i < int'(IMEM_DEPTH); i++) dut.MyInstr_Mem.IM[i] = prog[i];
        rst = 1'b0;
        model_edge(1'b1);
    endtask

    // Monitor: after every edge, pop the prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("pc", dut.pc, e.pc);
                chk($sformatf("reg x%0d", e.ridx), dut.MyregisterFile.register[e.ridx], e.rval);
                chk($sformatf("dmem DATA[%0d]", e.didx), dut.MyMDR.DATA[e.didx], e.dval);
            end
        end
    end

    // Stimulus: directed program, then random programs with random resets.
    initial begin
        for (int i = 0; i < int'(IMEM_DEPTH); i++) prog[i] = 32'h0;
        prog[0] = 32'h00500093;   // addi x1,x0,5
        prog[1] = 32'h00700113;   // addi x2,x0,7
        prog[2] = 32'h002081B3;   // add  x3,x1,x2
        prog[3] = 32'h00302423;   // sw   x3,8(x0)
        prog[4] = 32'h00802203;   // lw   x4,8(x0)
        prog[5] = 32'h00000463;   // beq  x0,x0,+8
        prog[6] = 32'h00100093;   // addi x1,x0,1 (skipped)
        prog[7] = 32'hFFFFFFFF;   // unsupported -> NOP
        prog[8] = 32'h00100013;   // addi x0,x0,1
        prog[9] = 32'hFFDFF0EF;   // jal  x1,-4
        for (int i = 0; i < int'(IMEM_DEPTH); i++) dut.MyInstr_Mem.IM[i] = prog[i];
        model_reset();

        do_edge(1'b0);
        do_edge(1'b0);
        settle();
        chk("reset pc", dut.pc, 32'h0);
        full_check();

        do_edge(1'b1); do_edge(1'b1); do_edge(1'b1);
        settle();
        chk("alu x1", dut.MyregisterFile.register[1], 32'd5);
        chk("alu x2", dut.MyregisterFile.register[2], 32'd7);
        chk("alu x3", dut.MyregisterFile.register[3], 32'd12);
        chk("alu pc", dut.pc, 32'hC);
        do_edge(1'b1); settle();
        chk("sw DATA[2]", dut.MyMDR.DATA[2], 32'h0000000C);
        do_edge(1'b1); settle();
        chk("lw x4", dut.MyregisterFile.register[4], 32'h0000000C);
        do_edge(1'b1); settle();
        chk("beq pc", dut.pc, 32'h1C);
        do_edge(1'b1); settle();
        chk("nop pc", dut.pc, 32'h20);
        chk("nop x1", dut.MyregisterFile.register[1], 32'd5);
        do_edge(1'b1); settle();
        chk("x0 stays 0", dut.MyregisterFile.register[0], 32'h0);
        do_edge(1'b1); settle();
        chk("jal x1", dut.MyregisterFile.register[1], 32'h28);
        chk("jal pc", dut.pc, 32'h20);
        do_edge(1'b0); settle();
        chk("midreset pc", dut.pc, 32'h0);
        chk("midreset x3", dut.MyregisterFile.register[3], 32'h0);
        chk("midreset DATA[2]", dut.MyMDR.DATA[2], 32'h0);
        full_check();

        for (int p = 0; p < 6; p++) begin
            load_random_program();
            repeat (300) do_edge(($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1);
            settle();
            full_check();
        end

        repeat (10) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
